// File: rtl/alu_instr_sequencer.sv
// Fetch/decode/execute control sequencer for a bus-based ALU datapath.
// Optional HI/LO writeback for MUL/DIV is enabled by defining HILO_WRITEBACK_EN.
module alu_instr_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Start,
  input  logic                MemReady,
  input  logic [31:0]         IR,
  output logic                Busy,
  output logic                Done,
  output logic                Illegal,
  output logic                PCout,
  output logic                MARin,
  output logic                IncPC,
  output logic                PCin,
  output logic                Read,
  output logic                MDRin,
  output logic                MDRout,
  output logic                IRin,
  output logic                Yin,
  output logic                ZLowin,
  output logic                ZHighin,
  output logic                ZLowout,
  output logic                ZHighout,
  output logic                HIin,
  output logic                LOin,
  output logic [NUM_REGS-1:0] Rout,
  output logic [NUM_REGS-1:0] Rin,
  output logic [OP_W-1:0]     OP
);

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    C_BIN, C_UNARY, C_MULDIV, C_ILL
  } cls_t;

  state_t     state, state_nx;
  cls_t       cls;
  logic       ill_q;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       unused_ir_low;

  assign opcode        = IR[31:27];
  assign ra            = IR[26:23];
  assign rb            = IR[22:19];
  assign rc            = IR[18:15];
  assign unused_ir_low = ^IR[14:0];

  function automatic logic reg_ok(input logic [3:0] r);
    return 32'(r) < NUM_REGS;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [3:0] r);
    logic [NUM_REGS-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) v[i] = (32'(r) == i);
    return v;
  endfunction

  // Out-of-range register fields fold into the illegal class, so later states
  // never need to re-check them before driving Rout/Rin.
  always_comb begin
    cls = C_ILL;
    if (opcode <= 5'h0C)
      cls = (reg_ok(ra) && reg_ok(rb) && reg_ok(rc)) ? C_BIN : C_ILL;
    else if (opcode == 5'h11 || opcode == 5'h12)
      cls = (reg_ok(ra) && reg_ok(rb)) ? C_UNARY : C_ILL;
`ifdef HILO_WRITEBACK_EN
    else if (opcode == 5'h0F || opcode == 5'h10)
      cls = (reg_ok(rb) && reg_ok(rc)) ? C_MULDIV : C_ILL;
`endif
  end

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state <= S_IDLE;
      ill_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_T3) ill_q <= (cls == C_ILL);
    end
  end

  always_comb begin
    state_nx = state;
    Busy     = (state != S_IDLE);
    Done     = 1'b0;
    Illegal  = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    ZLowin   = 1'b0;
    ZHighin  = 1'b0;
    ZLowout  = 1'b0;
    ZHighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rout     = '0;
    Rin      = '0;
    OP       = '0;
    case (state)
      S_IDLE: if (Start) state_nx = S_T0;
      S_T0: begin
        PCout    = 1'b1;
        MARin    = 1'b1;
        IncPC    = 1'b1;
        state_nx = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        if (MemReady) begin
          PCin     = 1'b1;
          state_nx = S_T2;
        end
      end
      S_T2: begin
        MDRout   = 1'b1;
        IRin     = 1'b1;
        state_nx = S_T3;
      end
      S_T3: begin
        case (cls)
          C_UNARY: begin
            Rout     = onehot(rb);
            ZLowin   = 1'b1;
            OP       = OP_W'(opcode);
            state_nx = S_T4;
          end
          C_BIN, C_MULDIV: begin
            Rout     = onehot(rb);
            Yin      = 1'b1;
            state_nx = S_T4;
          end
          default: state_nx = S_DONE;
        endcase
      end
      S_T4: begin
        case (cls)
          C_UNARY: begin
            ZLowout  = 1'b1;
            Rin      = onehot(ra);
            state_nx = S_DONE;
          end
          C_BIN, C_MULDIV: begin
            Rout     = onehot(rc);
            ZLowin   = 1'b1;
            ZHighin  = 1'b1;
            OP       = OP_W'(opcode);
            state_nx = S_T5;
          end
          default: state_nx = S_DONE;
        endcase
      end
      S_T5: begin
        state_nx = S_DONE;
        if (cls == C_BIN) begin
          ZLowout = 1'b1;
          Rin     = onehot(ra);
        end
`ifdef HILO_WRITEBACK_EN
        else if (cls == C_MULDIV) begin
          ZLowout  = 1'b1;
          LOin     = 1'b1;
          state_nx = S_T6;
        end
`endif
      end
      S_T6: begin
`ifdef HILO_WRITEBACK_EN
        ZHighout = 1'b1;
        HIin     = 1'b1;
`endif
        state_nx = S_DONE;
      end
      S_DONE: begin
        Done     = 1'b1;
        Illegal  = ill_q;
        state_nx = Start ? S_T0 : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Self-checking bench for alu_instr_sequencer: directed vector table, per-cycle
// corner sequences, and randomized instructions against a behavioural model.
module tb_alu_instr_sequencer;

`ifdef HILO_WRITEBACK_EN
  localparam bit HILO = 1'b1;
`else
  localparam bit HILO = 1'b0;
`endif

  logic        Clock, Clear, Start, MemReady;
  logic [31:0] IR;
  logic        Busy, Done, Illegal;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin;
  logic        ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin;
  logic [15:0] Rout, Rin;
  logic [4:0]  OP;

  logic        busy8, done8, illegal8;
  logic [14:0] s8;
  logic [7:0]  rout8, rin8;
  logic [4:0]  op8;

  alu_instr_sequencer #(.NUM_REGS(16), .OP_W(5)) dut (
    .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
    .Busy(Busy), .Done(Done), .Illegal(Illegal),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin), .Read(Read),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin),
    .ZHighin(ZHighin), .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin),
    .LOin(LOin), .Rout(Rout), .Rin(Rin), .OP(OP)
  );

  alu_instr_sequencer #(.NUM_REGS(8), .OP_W(5)) dut8 (
    .Clock(Clock), .Clear(Clear), .Start(Start), .MemReady(MemReady), .IR(IR),
    .Busy(busy8), .Done(done8), .Illegal(illegal8),
    .PCout(s8[14]), .MARin(s8[13]), .IncPC(s8[12]), .PCin(s8[11]), .Read(s8[10]),
    .MDRin(s8[9]), .MDRout(s8[8]), .IRin(s8[7]), .Yin(s8[6]), .ZLowin(s8[5]),
    .ZHighin(s8[4]), .ZLowout(s8[3]), .ZHighout(s8[2]), .HIin(s8[1]),
    .LOin(s8[0]), .Rout(rout8), .Rin(rin8), .OP(op8)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Strobe vector bit order: PCout MARin IncPC PCin Read MDRin MDRout IRin
  // Yin ZLowin ZHighin ZLowout ZHighout HIin LOin (bit 14 down to bit 0).
  typedef struct packed {
    logic [14:0] s;
    logic [15:0] rout;
    logic [15:0] rin;
    logic [4:0]  op;
    logic        busy;
    logic        done;
    logic        ill;
  } snap_t;

  typedef struct {
    logic [31:0] ir;
    int          stalls;
    int          lat;
    logic        ill;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
  } vec_t;

  typedef struct {
    int          lat;
    logic        ill;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [4:0]  op;
    int          lo;
    int          hi;
  } exp_t;

  int    checks = 0;
  int    failures = 0;
  snap_t trace [0:39];
  logic [15:0] acc_rin, acc_rout;
  logic [4:0]  acc_op;
  int    cnt_lo, cnt_hi, cnt_busy, cnt_pcin, onehot_bad;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic snap_t snap();
    snap_t t;
    t.s    = {PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin,
              ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin};
    t.rout = Rout;
    t.rin  = Rin;
    t.op   = OP;
    t.busy = Busy;
    t.done = Done;
    t.ill  = Illegal;
    return t;
  endfunction

  // Behavioural model: latency and register traffic follow from the class rules.
  function automatic exp_t model(input logic [31:0] ir, input int nregs);
    exp_t e;
    int op, ra, rb, rc;
    bit un, bin, md, ill;
    op  = int'(ir[31:27]);
    ra  = int'(ir[26:23]);
    rb  = int'(ir[22:19]);
    rc  = int'(ir[18:15]);
    un  = (op == 17 || op == 18);
    bin = (op <= 12);
    md  = HILO && (op == 15 || op == 16);
    ill = !(un || bin || md)
       || (un  && (ra >= nregs || rb >= nregs))
       || (bin && (ra >= nregs || rb >= nregs || rc >= nregs))
       || (md  && (rb >= nregs || rc >= nregs));
    e.ill  = ill;
    e.lat  = ill ? 4 : un ? 5 : bin ? 6 : 7;
    e.rin  = (!ill && (un || bin)) ? 16'(1 << ra) : 16'h0;
    e.rout = ill ? 16'h0 : un ? 16'(1 << rb) : 16'((1 << rb) | (1 << rc));
    e.op   = ill ? 5'h0 : 5'(op);
    e.lo   = (!ill && md) ? 1 : 0;
    e.hi   = e.lo;
    return e;
  endfunction

  // Cycle n counts negedges after the edge that samples Start (n=0 is T0).
  task automatic run_instr(input logic [31:0] ir, input int stalls, input int clear_at,
                           input bit rand_start, output int lat, output int lat8,
                           output logic ill8);
    acc_rin = '0; acc_rout = '0; acc_op = '0;
    cnt_lo = 0; cnt_hi = 0; cnt_busy = 0; cnt_pcin = 0; onehot_bad = 0;
    lat = -1; lat8 = -1; ill8 = 1'b0;
    @(negedge Clock);
    IR = ir; Start = 1'b1; MemReady = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge Clock);
      MemReady = !(n >= 1 && n <= stalls);
      Start    = (rand_start && n <= 3) ? 1'($urandom) : 1'b0;
      if (n == clear_at) Clear = 1'b1;
      #1;
      trace[n] = snap();
      if (n == clear_at) begin
        @(negedge Clock);
        Clear = 1'b0;
        return;
      end
      acc_rin  |= Rin;
      acc_rout |= Rout;
      acc_op   |= OP;
      cnt_lo   += int'(LOin);
      cnt_hi   += int'(HIin);
      cnt_busy += int'(Busy);
      cnt_pcin += int'(PCin);
      if ($countones(Rin) > 1 || $countones(Rout) > 1) onehot_bad++;
      if (done8 && lat8 < 0) begin
        lat8 = n;
        ill8 = illegal8;
      end
      if (Done) begin
        lat = n;
        break;
      end
    end
  endtask

  vec_t  vecs [9];
  exp_t  e16, e8;
  int    lat, lat8;
  logic  ill8;
  logic [31:0] rir;

  initial begin
    Clear = 1'b1; Start = 1'b0; MemReady = 1'b1; IR = '0;
    vecs[0] = '{32'h90080000, 0, 5, 1'b0, 16'h0001, 16'h0002, 5'h12};
    vecs[1] = '{32'h01890000, 0, 6, 1'b0, 16'h0008, 16'h0006, 5'h00};
    vecs[2] = '{32'h01890000, 3, 9, 1'b0, 16'h0008, 16'h0006, 5'h00};
    vecs[3] = '{32'hF8000000, 0, 4, 1'b1, 16'h0000, 16'h0000, 5'h00};
    vecs[4] = '{32'h89380000, 1, 6, 1'b0, 16'h0004, 16'h0080, 5'h11};
    vecs[5] = '{32'h67878000, 0, 6, 1'b0, 16'h8000, 16'h8001, 5'h0C};
    vecs[6] = '{32'h68000000, 2, 6, 1'b1, 16'h0000, 16'h0000, 5'h00};
`ifdef HILO_WRITEBACK_EN
    vecs[7] = '{32'h782B0000, 0, 7, 1'b0, 16'h0000, 16'h0060, 5'h0F};
    vecs[8] = '{32'h80098000, 0, 7, 1'b0, 16'h0000, 16'h000A, 5'h10};
`else
    vecs[7] = '{32'h782B0000, 0, 4, 1'b1, 16'h0000, 16'h0000, 5'h00};
    vecs[8] = '{32'h80098000, 0, 4, 1'b1, 16'h0000, 16'h0000, 5'h00};
`endif

    repeat (2) @(negedge Clock);
    #1;
    check("reset_outputs", 64'(snap()), 64'h0);
    @(negedge Clock);
    Clear = 1'b0;
    repeat (3) @(negedge Clock);
    #1;
    check("idle_after_reset", 64'(snap()), 64'h0);

    foreach (vecs[i]) begin
      run_instr(vecs[i].ir, vecs[i].stalls, -1, 1'b0, lat, lat8, ill8);
      check("vec_latency", 64'(lat), 64'(vecs[i].lat));
      check("vec_illegal", (lat >= 0) ? 64'(trace[lat].ill) : 64'hx, 64'(vecs[i].ill));
      check("vec_rin", 64'(acc_rin), 64'(vecs[i].rin));
      check("vec_rout", 64'(acc_rout), 64'(vecs[i].rout));
      check("vec_op", 64'(acc_op), 64'(vecs[i].op));
    end

    // NOT R0,R1: per-cycle strobes
    run_instr(32'h90080000, 0, -1, 1'b0, lat, lat8, ill8);
    check("not_t0_strobes", 64'(trace[0].s), 64'h7000);
    check("not_t1_strobes", 64'(trace[1].s), 64'h0E00);
    check("not_t2_strobes", 64'(trace[2].s), 64'h0180);
    check("not_t3_strobes", 64'(trace[3].s), 64'h0020);
    check("not_t3_rout", 64'(trace[3].rout), 64'h0002);
    check("not_t3_op", 64'(trace[3].op), 64'h12);
    check("not_t4_strobes", 64'(trace[4].s), 64'h0008);
    check("not_t4_rin", 64'(trace[4].rin), 64'h0001);
    check("not_t4_op", 64'(trace[4].op), 64'h0);
    check("not_done_flags", {62'h0, trace[5].done, trace[5].ill}, 64'h2);

    // ADD R3,R1,R2: per-cycle strobes
    run_instr(32'h01890000, 0, -1, 1'b0, lat, lat8, ill8);
    check("add_t3_strobes", 64'(trace[3].s), 64'h0040);
    check("add_t3_rout", 64'(trace[3].rout), 64'h0002);
    check("add_t4_strobes", 64'(trace[4].s), 64'h0030);
    check("add_t4_rout", 64'(trace[4].rout), 64'h0004);
    check("add_t5_strobes", 64'(trace[5].s), 64'h0008);
    check("add_t5_rin", 64'(trace[5].rin), 64'h0008);
    check("add_t5_rout", 64'(trace[5].rout), 64'h0000);

    // MemReady stalled for 3 T1 cycles
    run_instr(32'h01890000, 3, -1, 1'b0, lat, lat8, ill8);
    check("stall_read", {trace[1].s[10], trace[2].s[10], trace[3].s[10], trace[4].s[10]}, 64'hF);
    check("stall_mdrin", {trace[1].s[9], trace[2].s[9], trace[3].s[9], trace[4].s[9]}, 64'hF);
    check("stall_pcin", {trace[1].s[11], trace[2].s[11], trace[3].s[11], trace[4].s[11]}, 64'h1);
    check("stall_t2", 64'(trace[5].s), 64'h0180);
    check("stall_latency", 64'(lat), 64'd9);

    // MUL R5,R6
    run_instr(32'h782B0000, 0, -1, 1'b0, lat, lat8, ill8);
    if (HILO) begin
      check("mul_t5_strobes", 64'(trace[5].s), 64'h0009);
      check("mul_t6_strobes", 64'(trace[6].s), 64'h0006);
      check("mul_latency", 64'(lat), 64'd7);
    end else begin
      check("mul_latency", 64'(lat), 64'd4);
      check("mul_illegal", (lat >= 0) ? 64'(trace[lat].ill) : 64'hx, 64'h1);
    end
    check("mul_no_rin", 64'(acc_rin), 64'h0);
    check("mul_no_lohi_wo_macro", 64'(cnt_lo + cnt_hi), HILO ? 64'd2 : 64'd0);

    // Ra=8 on an 8-register instance is illegal; legal on 16
    run_instr(32'h94080000, 0, -1, 1'b0, lat, lat8, ill8);
    check("nr8_latency", 64'(lat8), 64'd4);
    check("nr8_illegal", 64'(ill8), 64'h1);
    check("nr16_legal", {lat[7:0], trace[5].ill}, {8'd5, 1'b0});

    // Clear during T4 of ADD, then restart
    run_instr(32'h01890000, 0, 4, 1'b0, lat, lat8, ill8);
    check("clear_t4_outputs", 64'(trace[4]), 64'h0);
    repeat (2) @(negedge Clock);
    #1;
    check("clear_stays_idle", 64'(snap()), 64'h0);
    run_instr(32'h01890000, 0, -1, 1'b0, lat, lat8, ill8);
    check("clear_restart_latency", 64'(lat), 64'd6);
    check("clear_restart_rin", 64'(acc_rin), 64'h0008);

    // Back-to-back: Start held during DONE goes straight to T0
    @(negedge Clock);
    IR = 32'h90080000; Start = 1'b1; MemReady = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    @(negedge Clock);
    Start = 1'b1;
    #1;
    check("b2b_first_done", 64'(Done), 64'h1);
    @(negedge Clock);
    Start = 1'b0;
    #1;
    check("b2b_t0", {Busy, PCout, MARin, IncPC, Done}, 64'h1E);
    repeat (5) @(negedge Clock);
    #1;
    check("b2b_second_done", 64'(Done), 64'h1);
    @(negedge Clock);

    // Random instructions against the model
    for (int k = 0; k < 60; k++) begin
      int st;
      rir = {5'($urandom_range(0, 31)), 4'($urandom), 4'($urandom), 4'($urandom), 15'($urandom)};
      st  = $urandom_range(0, 3);
      e16 = model(rir, 16);
      e8  = model(rir, 8);
      run_instr(rir, st, -1, 1'b1, lat, lat8, ill8);
      check("rnd_latency", 64'(lat), 64'(e16.lat + st));
      check("rnd_illegal", (lat >= 0) ? 64'(trace[lat].ill) : 64'hx, 64'(e16.ill));
      check("rnd_rin", 64'(acc_rin), 64'(e16.rin));
      check("rnd_rout", 64'(acc_rout), 64'(e16.rout));
      check("rnd_op", 64'(acc_op), 64'(e16.op));
      check("rnd_lo_hi", {32'(cnt_lo), 32'(cnt_hi)}, {32'(e16.lo), 32'(e16.hi)});
      check("rnd_busy_cycles", 64'(cnt_busy), 64'(e16.lat + st + 1));
      check("rnd_pcin_once", 64'(cnt_pcin), 64'd1);
      check("rnd_onehot", 64'(onehot_bad), 64'd0);
      check("rnd_nr8_latency", 64'(lat8), 64'(e8.lat + st));
      check("rnd_nr8_illegal", 64'(ill8), 64'(e8.ill));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
